// File: rtl/la_pwrdomain_ctrl.sv
// -----------------------------------------------------------------------------
// la_pwrdomain_ctrl
//   Power-domain sequencer for one switchable domain (header switches,
//   isolation cells, domain reset). Lives in the always-on domain.
//   Power-up: header groups are enabled one at a time, STAGEDLY cycles apart,
//   to limit inrush. The controller then waits for the synchronized ack from
//   the end of the switch chain, releases the domain reset, and after RSTDLY
//   cycles drops isolation. Power-down runs the mirror sequence: clamp,
//   assert reset, disable header groups in reverse, wait for ack low.
//
// Ports
//   clk        in   1        always-on clock
//   nreset     in   1        async active-low reset (sync deassert expected)
//   pwr_en     in   1        level request: 1 = domain on, 0 = domain off
//   pwr_ack    in   1        async ack from end of header chain (1 = rail up)
//   sleep      out  NSTAGES  header-group sleep, 1 = switch off
//   iso_en     out  1        isolation enable, 1 = outputs clamped
//   dom_nreset out  1        domain reset, active low
//   pwr_on     out  1        1 = domain fully on, isolation released
//   busy       out  1        1 = sequence in progress
//   err        out  1        sticky ack-timeout flag
//
// PROP is the implementation property string handed to the cell mapping; the
// sequencing logic itself does not depend on it.
// -----------------------------------------------------------------------------
module la_pwrdomain_ctrl #(
   parameter              PROP     = "DEFAULT",
   parameter int unsigned NSTAGES  = 4,
   parameter int unsigned STAGEDLY = 2,
   parameter int unsigned RSTDLY   = 3,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic               clk,
   input  logic               nreset,
   input  logic               pwr_en,
   input  logic               pwr_ack,
   output logic [NSTAGES-1:0] sleep,
   output logic               iso_en,
   output logic               dom_nreset,
   output logic               pwr_on,
   output logic               busy,
   output logic               err
);

   localparam int unsigned SW     = $clog2(NSTAGES + 1);
   localparam int unsigned DlyMax = (STAGEDLY > RSTDLY) ? STAGEDLY : RSTDLY;
   localparam int unsigned CntMax = (TIMEOUT > DlyMax) ? TIMEOUT : DlyMax;
   localparam int unsigned CW     = $clog2(CntMax + 1);

   localparam logic [SW-1:0] SFull     = SW'(NSTAGES);
   localparam logic [SW-1:0] SOne      = SW'(1);
   localparam logic [CW-1:0] StageLast = CW'(STAGEDLY - 1);
   localparam logic [CW-1:0] RstLast   = CW'(RSTDLY - 1);
   localparam logic [CW-1:0] ToLast    = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CntSat    = CW'(CntMax);

   typedef enum logic [2:0] {
      StOff,
      StUp,
      StWackUp,
      StRst,
      StOn,
      StIso,
      StDn,
      StWackDn
   } state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            blk_q, blk_d;
   logic            ack_meta_q, ack_s_q;

   logic [NSTAGES-1:0] sleep_d;
   logic               iso_d, dnr_d, pwr_on_d, busy_d;

   // ---------------------------------------------------------------------------
   // Ack synchronizer (pwr_ack comes from the switched rail, not this clock)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         ack_meta_q <= pwr_ack;
         ack_s_q    <= ack_meta_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      err_d   = err_q;
      // A timeout blocks retries until the request has been withdrawn once.
      blk_d   = pwr_en ? blk_q : 1'b0;

      unique case (state_q)
         StOff: begin
            if (pwr_en && !blk_q) begin
               state_d = StUp;
               s_d     = SOne;
               err_d   = 1'b0;
            end
         end

         StUp: begin
            if (!pwr_en) begin
               // Abort: ramp down from wherever the header chain currently is.
               state_d = StDn;
            end else if (cnt_q == StageLast) begin
               if (s_q == SFull) begin
                  state_d = StWackUp;
               end else begin
                  s_d = s_q + SOne;
               end
            end
         end

         StWackUp: begin
            if (!pwr_en) begin
               state_d = StDn;
            end else if (ack_s_q) begin
               state_d = StRst;
            end else if (cnt_q == ToLast) begin
               err_d   = 1'b1;
               blk_d   = 1'b1;
               state_d = StDn;
            end
         end

         StRst: begin
            if (!pwr_en) begin
               state_d = StIso;
            end else if (cnt_q == RstLast) begin
               state_d = StOn;
            end
         end

         StOn: begin
            if (!pwr_en) begin
               state_d = StIso;
            end
         end

         // One cycle with iso clamped and reset still released, so the clamp
         // is in place before the domain reset asserts.
         StIso: begin
            state_d = StDn;
         end

         StDn: begin
            if (s_q == '0) begin
               state_d = StWackDn;
            end else if (cnt_q == StageLast) begin
               s_d = s_q - SOne;
               if (s_q == SOne) begin
                  state_d = StWackDn;
               end
            end
         end

         StWackDn: begin
            if (!ack_s_q) begin
               state_d = StOff;
            end else if (cnt_q == ToLast) begin
               err_d   = 1'b1;
               state_d = StOff;
            end
         end

         default: begin
            state_d = StOff;
         end
      endcase

      // Dwell counter restarts on any state or stage change and saturates.
      if ((state_d != state_q) || (s_d != s_q)) begin
         cnt_d = '0;
      end else if (cnt_q != CntSat) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end

      // Outputs are decoded from next state and registered, so every output
      // pin is driven directly by a flop.
      for (int unsigned i = 0; i < NSTAGES; i++) begin
         sleep_d[i] = !(SW'(i) < s_d);
      end
      iso_d    = (state_d != StOn);
      dnr_d    = (state_d == StRst) || (state_d == StOn) || (state_d == StIso);
      pwr_on_d = (state_d == StOn);
      busy_d   = (state_d != StOff) && (state_d != StOn);
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= StOff;
         s_q        <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         blk_q      <= 1'b0;
         sleep      <= '1;
         iso_en     <= 1'b1;
         dom_nreset <= 1'b0;
         pwr_on     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         blk_q      <= blk_d;
         sleep      <= sleep_d;
         iso_en     <= iso_d;
         dom_nreset <= dnr_d;
         pwr_on     <= pwr_on_d;
         busy       <= busy_d;
      end
   end

   assign err = err_q;

endmodule
